// File: rtl/scan_seq_3x8_pkg.sv
// Shared definitions for the 3x8 decoder scan sequencer.
package scan_seq_3x8_pkg;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] I_MAX = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;
endpackage

// File: rtl/scan_seq_3x8_dwell_counter.sv
// Loadable hold counter: counts 0..limit while running, then wraps to 0.
// tc flags the last cycle of a hold.
module dwell_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         run_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == limit_i);

  // Next count: clear wins, otherwise wrap at the limit so the counter never overflows.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (run_i) cnt_d = tc_o ? '0 : cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/scan_seq_3x8.sv
// Scan sequencer driving a 3x8 decoder: steps I through 0..7, holding each
// value dwell+1 cycles, either once (mode=1) or continuously (mode=0).
module scan_seq_3x8
  import scan_seq_3x8_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               en,
  output logic [SEL_W-1:0]   I,
  output logic               busy,
  output logic               done,
  output logic               wrap
);
  state_e             state_q, state_d;
  logic [SEL_W-1:0]   I_q, I_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic               hold_tc;
  logic               hold_clr;

  // Counter sits at zero in IDLE and on abort, so every scan starts from a fresh hold.
  assign hold_clr = (state_q == IDLE) || stop;

  dwell_counter #(.W(DWELL_W)) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (hold_clr),
    .run_i   (state_q == SCAN),
    .limit_i (dwell_q),
    .tc_o    (hold_tc)
  );

  // Outputs come straight from state registers; en is the inverse of busy.
  assign busy = (state_q == SCAN);
  assign en   = (state_q != SCAN);
  assign I    = I_q;
  assign done = done_q;
  assign wrap = wrap_q;

  // Next-state and pulse logic; stop outranks hold expiry.
  always_comb begin
    state_d = state_q;
    I_d     = I_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = SCAN;
          I_d     = '0;
          dwell_d = dwell;
          mode_d  = mode;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          I_d     = '0;
        end else if (hold_tc) begin
          if (I_q != I_MAX) begin
            I_d = I_q + SEL_W'(1);
          end else if (mode_q) begin
            state_d = IDLE;
            I_d     = '0;
            done_d  = 1'b1;
          end else begin
            I_d    = '0;
            wrap_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      I_q     <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      I_q     <= I_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end
endmodule
